// File: rtl/panel_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : panel_loader_pkg
// Purpose  : Shared types and constants for the front-panel image loader:
//            sequencer state encodings, press phase and button-select types,
//            and the default start PC.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package panel_loader_pkg;

  // Conventional PDP-8 program origin.
  localparam logic [11:0] DEFAULT_START_PC = 12'o0200;

  typedef enum logic [1:0] {
    PH_SETUP   = 2'd0,
    PH_PRESS   = 2'd1,
    PH_RELEASE = 2'd2
  } press_phase_t;

  typedef enum logic {
    SEL_LOADPC  = 1'b0,
    SEL_DEPOSIT = 1'b1
  } btn_sel_t;

  typedef logic [2:0] panel_state_t;

  localparam panel_state_t ST_IDLE      = 3'd0;
  localparam panel_state_t ST_CHECK     = 3'd1;
  localparam panel_state_t ST_LOADPC    = 3'd2;
  localparam panel_state_t ST_DEPOSIT   = 3'd3;
  localparam panel_state_t ST_START     = 3'd4;
  localparam panel_state_t ST_RUN       = 3'd5;
  localparam panel_state_t ST_WAIT_HALT = 3'd6;
  localparam panel_state_t ST_DONE      = 3'd7;

endpackage
`default_nettype wire

// File: rtl/panel_press.sv
`default_nettype none
// ============================================================================
// Module   : panel_press
// Purpose  : Performs one timed front-panel button press: switches set up for
//            HOLD cycles, selected button high for HOLD cycles, released for
//            HOLD cycles (3*HOLD cycles in total).
// Ports    : clock, resetN   - clock, async active-low reset
//            start          - begin a press (ignored while one is active)
//            btn_sel, value - which button to press and switch value to show
//            sw_val         - switch value, held from press entry onward
//            load_pc_btn, deposit_btn - panel buttons
//            finished       - high in the last cycle of a press
// Revision : 1.0 - initial release
// ============================================================================
module panel_press
  import panel_loader_pkg::*;
#(
  parameter int WORD_W = 12,
  parameter int HOLD   = 10
) (
  input  logic              clock,
  input  logic              resetN,
  input  logic              start,
  input  btn_sel_t          btn_sel,
  input  logic [WORD_W-1:0] value,
  output logic [WORD_W-1:0] sw_val,
  output logic              load_pc_btn,
  output logic              deposit_btn,
  output logic              finished
);

  localparam logic [7:0] HOLD_M1 = 8'(HOLD - 1);

  logic         active;
  press_phase_t phase;
  logic [7:0]   cnt;
  btn_sel_t     sel;
  logic [WORD_W-1:0] val;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      active <= 1'b0;
      phase  <= PH_SETUP;
      cnt    <= 8'd0;
      sel    <= SEL_LOADPC;
      val    <= '0;
    end else if (!active) begin
      if (start) begin
        active <= 1'b1;
        phase  <= PH_SETUP;
        cnt    <= HOLD_M1;
        sel    <= btn_sel;
        val    <= value;
      end
    end else if (cnt == 8'd0) begin
      cnt <= HOLD_M1;
      case (phase)
        PH_SETUP: phase <= PH_PRESS;
        PH_PRESS: phase <= PH_RELEASE;
        default: begin
          active <= 1'b0;
          phase  <= PH_SETUP;
        end
      endcase
    end else begin
      cnt <= cnt - 8'd1;
    end
  end

  // Buttons are decoded from registered state so an async reset drops them
  // in the same cycle.
  logic btn_on;
  assign btn_on      = active && (phase == PH_PRESS);
  assign load_pc_btn = btn_on && (sel == SEL_LOADPC);
  assign deposit_btn = btn_on && (sel == SEL_DEPOSIT);
  assign finished    = active && (phase == PH_RELEASE) && (cnt == 8'd0);
  assign sw_val      = val;

endmodule
`default_nettype wire

// File: rtl/panel_loader.sv
`default_nettype none
// ============================================================================
// Module   : panel_loader
// Purpose  : Front-panel sequencer. Takes (address, data) records over a
//            valid/ready stream, deposits each word via Load PC / Deposit
//            presses (Load PC skipped when the panel's auto-incremented
//            address already matches), then loads START_PC, raises run and
//            reports done once the CPU run LED falls.
// Ports    : clock, resetN                 - clock, async active-low reset
//            rec_valid/ready/addr/data/last - record stream
//            run_led                       - CPU run indicator
//            sw, load_pc_btn, deposit_btn  - panel controls (sw[WORD_W]=run)
//            busy, done, dep_count         - status
// Revision : 1.0 - initial release
// ============================================================================
module panel_loader
  import panel_loader_pkg::*;
#(
  parameter int                WORD_W   = 12,
  parameter int                HOLD     = 10,
  parameter logic [WORD_W-1:0] START_PC = WORD_W'(DEFAULT_START_PC),
  parameter int                CNT_W    = 16
) (
  input  logic              clock,
  input  logic              resetN,
  input  logic              rec_valid,
  output logic              rec_ready,
  input  logic [WORD_W-1:0] rec_addr,
  input  logic [WORD_W-1:0] rec_data,
  input  logic              rec_last,
  input  logic              run_led,
  output logic [WORD_W:0]   sw,
  output logic              load_pc_btn,
  output logic              deposit_btn,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  dep_count
);

  localparam logic [7:0] HOLD_M1 = 8'(HOLD - 1);

  panel_state_t      state;
  logic              armed;      // keeps rec_ready low until the first clock after reset
  logic [WORD_W-1:0] addr_q;
  logic [WORD_W-1:0] data_q;
  logic              last_q;
  logic [WORD_W-1:0] exp_addr;
  logic              exp_valid;
  logic              pressing;   // a press for the current state has been launched
  logic [7:0]        run_cnt;
  logic              seen_high;

  logic              press_start;
  btn_sel_t          press_sel;
  logic [WORD_W-1:0] press_value;
  logic [WORD_W-1:0] press_sw;
  logic              press_finished;

  always_comb begin
    press_start = 1'b0;
    press_sel   = SEL_LOADPC;
    press_value = addr_q;
    case (state)
      ST_LOADPC: press_start = !pressing;
      ST_DEPOSIT: begin
        press_start = !pressing;
        press_sel   = SEL_DEPOSIT;
        press_value = data_q;
      end
      ST_START: begin
        press_start = !pressing;
        press_value = START_PC;
      end
      default: ;
    endcase
  end

  panel_press #(
    .WORD_W (WORD_W),
    .HOLD   (HOLD)
  ) u_press (
    .clock       (clock),
    .resetN      (resetN),
    .start       (press_start),
    .btn_sel     (press_sel),
    .value       (press_value),
    .sw_val      (press_sw),
    .load_pc_btn (load_pc_btn),
    .deposit_btn (deposit_btn),
    .finished    (press_finished)
  );

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state     <= ST_IDLE;
      armed     <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      last_q    <= 1'b0;
      exp_addr  <= '0;
      exp_valid <= 1'b0;
      pressing  <= 1'b0;
      run_cnt   <= 8'd0;
      seen_high <= 1'b0;
      dep_count <= '0;
    end else begin
      armed <= 1'b1;

      if (press_start) begin
        pressing <= 1'b1;
      end else if (press_finished) begin
        pressing <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (rec_valid && rec_ready) begin
            addr_q <= rec_addr;
            data_q <= rec_data;
            last_q <= rec_last;
            state  <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (!exp_valid || (addr_q != exp_addr)) begin
            state <= ST_LOADPC;
          end else begin
            state <= ST_DEPOSIT;
          end
        end
        ST_LOADPC: begin
          if (press_finished) state <= ST_DEPOSIT;
        end
        ST_DEPOSIT: begin
          if (press_finished) begin
            // The panel auto-increments after a deposit; track where it points.
            exp_addr  <= addr_q + 1'b1;
            exp_valid <= 1'b1;
            if (dep_count != '1) dep_count <= dep_count + 1'b1;
            state <= last_q ? ST_START : ST_IDLE;
          end
        end
        ST_START: begin
          if (press_finished) begin
            run_cnt   <= HOLD_M1;
            seen_high <= 1'b0;
            state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (run_cnt == 8'd0) begin
            state <= ST_WAIT_HALT;
          end else begin
            run_cnt <= run_cnt - 8'd1;
          end
        end
        ST_WAIT_HALT: begin
          // A LED already high on entry counts as seen; only a fall after
          // that means the program halted.
          seen_high <= seen_high | run_led;
          if (seen_high && !run_led) state <= ST_DONE;
        end
        default: ;
      endcase
    end
  end

  logic run_sw;
  assign run_sw    = (state == ST_RUN) || (state == ST_WAIT_HALT);
  assign sw        = {run_sw, press_sw};
  assign rec_ready = armed && (state == ST_IDLE);
  assign busy      = (state != ST_IDLE) && (state != ST_DONE);
  assign done      = (state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_panel_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_panel_loader
// Purpose  : Directed self-checking bench for panel_loader (WORD_W=12,
//            HOLD=10, START_PC=0200): reset mid-press, contiguous image,
//            scattered image, address wrap, run/halt handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_panel_loader;

  logic        clock = 1'b0;
  logic        resetN;
  logic        rec_valid;
  logic        rec_ready;
  logic [11:0] rec_addr;
  logic [11:0] rec_data;
  logic        rec_last;
  logic        run_led;
  logic [12:0] sw;
  logic        load_pc_btn;
  logic        deposit_btn;
  logic        busy;
  logic        done;
  logic [15:0] dep_count;

  int vectors    = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  panel_loader #(
    .WORD_W   (12),
    .HOLD     (10),
    .START_PC (12'o0200),
    .CNT_W    (16)
  ) dut (
    .clock       (clock),
    .resetN      (resetN),
    .rec_valid   (rec_valid),
    .rec_ready   (rec_ready),
    .rec_addr    (rec_addr),
    .rec_data    (rec_data),
    .rec_last    (rec_last),
    .run_led     (run_led),
    .sw          (sw),
    .load_pc_btn (load_pc_btn),
    .deposit_btn (deposit_btn),
    .busy        (busy),
    .done        (done),
    .dep_count   (dep_count)
  );

  // Press monitor: logs switch value at each button rise, deposit-button
  // high time, and cycles with rec_ready high.
  logic [11:0] lp_q[$];
  logic [11:0] dp_q[$];
  int          dp_len_q[$];
  int          dp_hi = 0;
  int          ready_cycles = 0;
  logic        lp_prev = 1'b0;
  logic        dp_prev = 1'b0;

  always @(negedge clock) begin
    if (load_pc_btn && !lp_prev) lp_q.push_back(sw[11:0]);
    if (deposit_btn && !dp_prev) dp_q.push_back(sw[11:0]);
    if (deposit_btn) dp_hi = dp_hi + 1;
    if (!deposit_btn && dp_prev) begin
      dp_len_q.push_back(dp_hi);
      dp_hi = 0;
    end
    if (rec_ready) ready_cycles = ready_cycles + 1;
    lp_prev = load_pc_btn;
    dp_prev = deposit_btn;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors = vectors + 1;
    assert (obs === exp) else begin
      miscompares = miscompares + 1;
      $error("FAIL %s: observed %0o expected %0o", tag, obs, exp);
    end
  endtask

  // Present a record and wait (bounded) for its handshake; valid is left high.
  task automatic send(input logic [11:0] a, input logic [11:0] d, input logic l);
    int n;
    rec_addr  = a;
    rec_data  = d;
    rec_last  = l;
    rec_valid = 1'b1;
    n = 0;
    while (!rec_ready && n < 3000) begin
      @(negedge clock);
      n = n + 1;
    end
    check("handshake_timeout", {31'd0, rec_ready}, 32'd1);
    @(posedge clock);
    #1;
  endtask

  task automatic wait_run_sw();
    int n;
    n = 0;
    while (!sw[12] && n < 3000) begin
      @(negedge clock);
      n = n + 1;
    end
    check("run_sw_timeout", {31'd0, sw[12]}, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clock);
    resetN    = 1'b0;
    rec_valid = 1'b0;
    run_led   = 1'b0;
    repeat (2) @(negedge clock);
    resetN = 1'b1;
    @(negedge clock);
  endtask

  int lp_b, dp_b, len_b, rdy_b, n;

  initial begin
    resetN    = 1'b0;
    rec_valid = 1'b0;
    rec_addr  = '0;
    rec_data  = '0;
    rec_last  = 1'b0;
    run_led   = 1'b0;
    repeat (2) @(negedge clock);
    resetN = 1'b1;
    @(negedge clock);

    // ---- Reset in the middle of a Load PC press ----
    send(12'o0010, 12'o1111, 1'b0);
    rec_valid = 1'b0;
    n = 0;
    while (!load_pc_btn && n < 200) begin
      @(negedge clock);
      n = n + 1;
    end
    check("lp_btn_before_reset", {31'd0, load_pc_btn}, 32'd1);
    #2 resetN = 1'b0;
    #1;
    check("rst_load_pc_btn", {31'd0, load_pc_btn}, 32'd0);
    check("rst_deposit_btn", {31'd0, deposit_btn}, 32'd0);
    check("rst_sw", {19'd0, sw}, 32'd0);
    check("rst_rec_ready", {31'd0, rec_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_dep_count", {16'd0, dep_count}, 32'd0);

    // ---- Contiguous image, rec_valid held high throughout ----
    @(negedge clock);
    rec_addr  = 12'o0200;
    rec_data  = 12'o7300;
    rec_last  = 1'b0;
    rec_valid = 1'b1;
    lp_b = lp_q.size(); dp_b = dp_q.size(); len_b = dp_len_q.size();
    rdy_b = ready_cycles;
    @(negedge clock);
    resetN = 1'b1;
    #1;
    check("ready_low_at_release", {31'd0, rec_ready}, 32'd0);
    @(negedge clock);
    check("ready_one_cycle_after", {31'd0, rec_ready}, 32'd1);
    send(12'o0200, 12'o7300, 1'b0);
    send(12'o0201, 12'o1205, 1'b0);
    send(12'o0202, 12'o7402, 1'b1);
    rec_valid = 1'b0;
    check("busy_during_image", {31'd0, busy}, 32'd1);
    wait_run_sw();
    repeat (5) @(negedge clock);
    run_led = 1'b1;
    repeat (100) @(negedge clock);
    run_led = 1'b0;
    #1;
    check("done_before_fall_seen", {31'd0, done}, 32'd0);
    @(negedge clock);
    check("done_after_fall", {31'd0, done}, 32'd1);
    check("run_sw_dropped", {31'd0, sw[12]}, 32'd0);
    check("busy_after_done", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clock);
    check("ready_low_in_done", {31'd0, rec_ready}, 32'd0);
    check("done_sticky", {31'd0, done}, 32'd1);
    check("t2_dep_count", {16'd0, dep_count}, 32'd3);
    check("t2_ready_cycles", ready_cycles - rdy_b, 32'd3);
    check("t2_lp_count", lp_q.size() - lp_b, 32'd2);
    check("t2_lp0", {20'd0, lp_q[lp_b]}, 32'o0200);
    check("t2_lp1", {20'd0, lp_q[lp_b + 1]}, 32'o0200);
    check("t2_dp_count", dp_q.size() - dp_b, 32'd3);
    check("t2_dp0", {20'd0, dp_q[dp_b]}, 32'o7300);
    check("t2_dp1", {20'd0, dp_q[dp_b + 1]}, 32'o1205);
    check("t2_dp2", {20'd0, dp_q[dp_b + 2]}, 32'o7402);
    check("t2_dp_len0", dp_len_q[len_b], 32'd10);
    check("t2_dp_len1", dp_len_q[len_b + 1], 32'd10);
    check("t2_dp_len2", dp_len_q[len_b + 2], 32'd10);

    // ---- Scattered image; run LED never rises ----
    do_reset();
    lp_b = lp_q.size(); dp_b = dp_q.size();
    send(12'o0010, 12'o1111, 1'b0);
    rec_valid = 1'b0;
    send(12'o0400, 12'o2222, 1'b1);
    rec_valid = 1'b0;
    wait_run_sw();
    repeat (200) @(negedge clock);
    check("t3_no_led_done", {31'd0, done}, 32'd0);
    check("t3_no_led_busy", {31'd0, busy}, 32'd1);
    check("t3_run_sw_held", {31'd0, sw[12]}, 32'd1);
    check("t3_dep_count", {16'd0, dep_count}, 32'd2);
    check("t3_lp_count", lp_q.size() - lp_b, 32'd3);
    check("t3_lp0", {20'd0, lp_q[lp_b]}, 32'o0010);
    check("t3_lp1", {20'd0, lp_q[lp_b + 1]}, 32'o0400);
    check("t3_lp2", {20'd0, lp_q[lp_b + 2]}, 32'o0200);
    check("t3_dp_count", dp_q.size() - dp_b, 32'd2);
    check("t3_dp0", {20'd0, dp_q[dp_b]}, 32'o1111);
    check("t3_dp1", {20'd0, dp_q[dp_b + 1]}, 32'o2222);

    // ---- Address wrap 7777 -> 0000; LED already high entering halt wait ----
    do_reset();
    lp_b = lp_q.size(); dp_b = dp_q.size();
    send(12'o7777, 12'o0001, 1'b0);
    send(12'o0000, 12'o0002, 1'b1);
    rec_valid = 1'b0;
    wait_run_sw();
    run_led = 1'b1;
    repeat (30) @(negedge clock);
    check("t4_led_high_not_done", {31'd0, done}, 32'd0);
    run_led = 1'b0;
    @(negedge clock);
    check("t4_done_after_fall", {31'd0, done}, 32'd1);
    check("t4_dep_count", {16'd0, dep_count}, 32'd2);
    check("t4_lp_count", lp_q.size() - lp_b, 32'd2);
    check("t4_lp0", {20'd0, lp_q[lp_b]}, 32'o7777);
    check("t4_lp1", {20'd0, lp_q[lp_b + 1]}, 32'o0200);
    check("t4_dp_count", dp_q.size() - dp_b, 32'd2);
    check("t4_dp0", {20'd0, dp_q[dp_b]}, 32'o0001);
    check("t4_dp1", {20'd0, dp_q[dp_b + 1]}, 32'o0002);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/panel_loader.md
Name: panel_loader

Overview:
- Synthesizable front-panel sequencer; replaces the hand-timed Load_PC/Deposit bench tasks.
- Accepts (address, data) image records over a valid/ready stream and drives the Front_Panel switch/button inputs to deposit each word. Issues a Load PC only when the target address is not the panel's auto-incremented next address.
- After the last record, loads the start PC, raises the run switch, and reports completion when the CPU run LED falls.
- Sits between the emulator transactor (record source) and Front_Panel.

Parameters:
- WORD_W, 12, data/address width; panel switch bus is WORD_W+1 bits, top bit is the run switch.
- HOLD, 10, clock cycles spent in each press phase (switch setup, button high, button low); legal range 1..255.
- START_PC, 12'o0200, PC loaded before run; width WORD_W.
- CNT_W, 16, width of the deposit counter.

Ports:
- clock  input  1  system clock.
- resetN  input  1  asynchronous active-low reset.
- rec_valid  input  1  record present.
- rec_ready  output  1  loader can accept a record.
- rec_addr  input  WORD_W  target address.
- rec_data  input  WORD_W  word to deposit.
- rec_last  input  1  final record of image.
- run_led  input  1  CPU run indicator (Front_Panel led[WORD_W]).
- sw  output  WORD_W+1  panel switches; [WORD_W] is run.
- load_pc_btn  output  1  Load PC button.
- deposit_btn  output  1  Deposit button.
- busy  output  1  sequence in progress (not IDLE, not DONE).
- done  output  1  program ran and halted; sticky until reset.
- dep_count  output  CNT_W  deposits performed; saturates at all-ones.

Behaviour:
- Reset (async, resetN=0): sw=0, load_pc_btn=0, deposit_btn=0, rec_ready=0, busy=0, done=0, dep_count=0, exp_valid=0, FSM=IDLE. Asserting resetN low mid-press drops buttons immediately. No resumption after reset; the source must restart the image.
- States:
  - IDLE: rec_ready=1. On rec_valid&&rec_ready, capture addr/data/last, then go to CHECK.
  - CHECK: if !exp_valid or addr!=exp_addr, go to LOADPC; otherwise go to DEPOSIT.
  - LOADPC: press load_pc_btn with sw[WORD_W-1:0]=addr, then go to DEPOSIT.
  - DEPOSIT: press deposit_btn with sw=data. Then set exp_addr=addr+1 mod 2^WORD_W, exp_valid=1, dep_count+1. If last, go to START; otherwise go to IDLE.
  - START: press load_pc_btn with START_PC, then go to RUN.
  - RUN: hold sw[WORD_W]=1 for HOLD cycles, then go to WAIT_HALT.
  - WAIT_HALT: once run_led has been seen high, wait for it to fall, then go to DONE.
  - DONE: done=1, run switch dropped to 0, rec_ready=0.
- Press timing: each press is exactly 3*HOLD cycles.
  - Switch value is driven at press entry and held through all 3 phases.
  - Button is high for exactly HOLD cycles, starting HOLD cycles after entry.
- rec_ready is 0 in all states except IDLE. A record is never dropped or duplicated.
- Address wrap: a record at 2^WORD_W-1 followed by one at 0 deposits contiguously with no Load PC.
- rec_last on the first record: one deposit, then START.
- run_led already high on entering WAIT_HALT: still wait for the falling edge.
- run_led never rising: the block stays in WAIT_HALT (bench timeout).
- sw[WORD_W] stays 0 outside RUN and WAIT_HALT.

Decomposition:
- Shared package (CPU_Definitions or memory_utils): panel_state_t enum; press phase enum {PH_SETUP, PH_PRESS, PH_RELEASE}; localparam for default START_PC.
- Sub-module panel_press: inputs start, btn_sel (LOADPC/DEPOSIT), value; outputs sw value, load_pc_btn, deposit_btn, finished. Holds the HOLD phase counter.
- Main FSM lives in panel_loader.

Test Plan:
- Reset held mid-LOADPC press (button high) -> load_pc_btn=0 same cycle; all outputs at reset values; rec_ready=1 one cycle after resetN rises.
- Records {0200:7300, 0201:1205, 0202:7402 last}, HOLD=10 -> exactly two Load PC presses (0200, then START_PC 0200) and three deposits; deposit buttons high 10 cycles each; dep_count=3.
- Records {0010:1111, 0400:2222 last} -> Load PC 0010, deposit, Load PC 0400, deposit, Load PC 0200; no extra presses.
- WORD_W=12, records {7777:0001, 0000:0002 last} -> single Load PC at 7777; second deposit without Load PC; dep_count=2.
- rec_valid held high continuously -> rec_ready pulses once per record only in IDLE; no record lost; sampled sw values match data order.
- After last record, run_led rises 5 cycles after run switch then falls 100 cycles later -> done=1 one cycle after the fall; sw[12]=0; rec_ready stays 0.
